// File: rtl/fpu_ss_fpr_wb_arbiter.sv
// Arbitrates the single FPR write port between the FPU result path and the cmem load path, each with a 1-entry slot.
// Latency: a captured result is written one cycle after capture at the earliest; fpr_we_o depends only on registered slot state, wb_block_i and reset.
// Backpressure: *_ready_o drops while that slot is full and not draining; wb_block_i stalls all writes and holds every slot and the grant state.
module fpu_ss_fpr_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fpu_valid_i,
    output logic                  fpu_ready_o,
    input  logic [ADDR_WIDTH-1:0] fpu_addr_i,
    input  logic [DATA_WIDTH-1:0] fpu_data_i,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  wb_block_i,
    output logic                  fpr_we_o,
    output logic [ADDR_WIDTH-1:0] fpr_waddr_o,
    output logic [DATA_WIDTH-1:0] fpr_wdata_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_FPU  = 2'd1,
        SRC_MEM  = 2'd2
    } src_e;

    logic                  fpu_full_q, fpu_full_d;
    logic [ADDR_WIDTH-1:0] fpu_addr_q, fpu_addr_d;
    logic [DATA_WIDTH-1:0] fpu_data_q, fpu_data_d;
    logic                  mem_full_q, mem_full_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    src_e                  older_q, older_d;
    src_e                  last_grant_q, last_grant_d;

    logic gnt_fpu, gnt_mem, wr_en, fpu_wr, mem_wr, fpu_cap, mem_cap;

    // Grant selection from registered state only: single occupant, else older slot, else round-robin.
    always_comb begin
        gnt_fpu = fpu_full_q & (~mem_full_q
                                | (older_q == SRC_FPU)
                                | ((older_q == SRC_NONE) & (last_grant_q == SRC_MEM)));
        gnt_mem = mem_full_q & ~gnt_fpu;
        // Gating with rst_ni keeps a reset beat from leaking a write out of a slot being discarded.
        wr_en   = (fpu_full_q | mem_full_q) & ~wb_block_i & rst_ni;
        fpu_wr  = gnt_fpu & wr_en;
        mem_wr  = gnt_mem & wr_en;
        fpu_ready_o = ~fpu_full_q | fpu_wr;
        mem_ready_o = ~mem_full_q | mem_wr;
        fpu_cap = fpu_valid_i & fpu_ready_o;
        mem_cap = mem_valid_i & mem_ready_o;
        fpr_we_o    = wr_en;
        fpr_waddr_o = '0;
        fpr_wdata_o = '0;
        if (fpu_wr) begin
            fpr_waddr_o = fpu_addr_q;
            fpr_wdata_o = fpu_data_q;
        end else if (mem_wr) begin
            fpr_waddr_o = mem_addr_q;
            fpr_wdata_o = mem_data_q;
        end
        busy_o = fpu_full_q | mem_full_q;
    end

    // Next slot contents, age order and round-robin pointer.
    always_comb begin
        fpu_full_d   = fpu_cap | (fpu_full_q & ~fpu_wr);
        fpu_addr_d   = fpu_cap ? fpu_addr_i : fpu_addr_q;
        fpu_data_d   = fpu_cap ? fpu_data_i : fpu_data_q;
        mem_full_d   = mem_cap | (mem_full_q & ~mem_wr);
        mem_addr_d   = mem_cap ? mem_addr_i : mem_addr_q;
        mem_data_d   = mem_cap ? mem_data_i : mem_data_q;
        last_grant_d = last_grant_q;
        if (fpu_wr) begin
            last_grant_d = SRC_FPU;
        end else if (mem_wr) begin
            last_grant_d = SRC_MEM;
        end
        // A slot filled this cycle is younger than one that stayed full; simultaneous fills tie.
        older_d = older_q;
        if (!(fpu_full_d && mem_full_d)) begin
            older_d = SRC_NONE;
        end else if (fpu_cap && mem_cap) begin
            older_d = SRC_NONE;
        end else if (fpu_cap) begin
            older_d = SRC_MEM;
        end else if (mem_cap) begin
            older_d = SRC_FPU;
        end
    end

    // State registers with synchronous active-low reset; reset discards slot contents.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fpu_full_q   <= 1'b0;
            fpu_addr_q   <= '0;
            fpu_data_q   <= '0;
            mem_full_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            older_q      <= SRC_NONE;
            last_grant_q <= SRC_MEM;
        end else begin
            fpu_full_q   <= fpu_full_d;
            fpu_addr_q   <= fpu_addr_d;
            fpu_data_q   <= fpu_data_d;
            mem_full_q   <= mem_full_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            older_q      <= older_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_fpu_ss_fpr_wb_arbiter.sv
module tb_fpu_ss_fpr_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        fpu_valid_i, fpu_ready_o;
    logic [4:0]  fpu_addr_i;
    logic [31:0] fpu_data_i;
    logic        mem_valid_i, mem_ready_o;
    logic [4:0]  mem_addr_i;
    logic [31:0] mem_data_i;
    logic        wb_block_i;
    logic        fpr_we_o;
    logic [4:0]  fpr_waddr_o;
    logic [31:0] fpr_wdata_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] regfile [32];

    always #5 clk_i = ~clk_i;

    fpu_ss_fpr_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o),
        .fpu_addr_i(fpu_addr_i), .fpu_data_i(fpu_data_i),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .wb_block_i(wb_block_i),
        .fpr_we_o(fpr_we_o), .fpr_waddr_o(fpr_waddr_o), .fpr_wdata_o(fpr_wdata_o),
        .busy_o(busy_o)
    );

    // Shadow register file fed by observed writes.
    always @(negedge clk_i) if (fpr_we_o === 1'b1) regfile[fpr_waddr_o] <= fpr_wdata_o;

    typedef struct {
        bit rst_n; bit fv; logic [4:0] fa; logic [31:0] fd;
        bit mv; logic [4:0] ma; logic [31:0] md; bit blk;
        bit we; logic [4:0] wa; logic [31:0] wd; bit fr; bit mr; bit busy;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(bit rst_n, bit fv, logic [4:0] fa, logic [31:0] fd,
                                bit mv, logic [4:0] ma, logic [31:0] md, bit blk,
                                bit we, logic [4:0] wa, logic [31:0] wd, bit fr, bit mr, bit busy);
        vec_t v;
        v.rst_n = rst_n; v.fv = fv; v.fa = fa; v.fd = fd; v.mv = mv; v.ma = ma; v.md = md; v.blk = blk;
        v.we = we; v.wa = wa; v.wd = wd; v.fr = fr; v.mr = mr; v.busy = busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst_n, input bit fv, input logic [4:0] fa, input logic [31:0] fd,
                         input bit mv, input logic [4:0] ma, input logic [31:0] md, input bit blk);
        rst_ni = rst_n; fpu_valid_i = fv; fpu_addr_i = fa; fpu_data_i = fd;
        mem_valid_i = mv; mem_addr_i = ma; mem_data_i = md; wb_block_i = blk;
    endtask

    task automatic check_outs(input string tag, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                              input bit fr, input bit mr, input bit busy);
        check({tag, ".we"},    {31'd0, fpr_we_o},    {31'd0, we});
        check({tag, ".waddr"}, {27'd0, fpr_waddr_o}, {27'd0, wa});
        check({tag, ".wdata"}, fpr_wdata_o,          wd);
        check({tag, ".fpu_rdy"}, {31'd0, fpu_ready_o}, {31'd0, fr});
        check({tag, ".mem_rdy"}, {31'd0, mem_ready_o}, {31'd0, mr});
        check({tag, ".busy"},  {31'd0, busy_o},      {31'd0, busy});
    endtask

    // Reference model: each slot remembers the cycle it was filled; oldest fill wins, ties alternate.
    typedef struct { bit full; logic [4:0] addr; logic [31:0] data; int born; } slot_t;
    slot_t m_fpu, m_mem;
    bit    m_last_mem;
    int    cyc;

    task automatic model_reset();
        m_fpu = '{0, 5'd0, 32'd0, 0};
        m_mem = '{0, 5'd0, 32'd0, 0};
        m_last_mem = 1'b1;
    endtask

    task automatic apply_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1 drive(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    localparam logic [31:0] ONE_F = 32'h3F80_0000;
    localparam logic [31:0] DAT_A = 32'hAAAA_0005;
    localparam logic [31:0] DAT_B = 32'hBBBB_0005;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) regfile[i] = 32'd0;
        @(posedge clk_i); #1;
        apply_reset();

        //          rst fv fa  fd        mv ma  md      blk  we wa  wd      fr mr busy
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        0,   0, 0, 0,        1, 1, 0)); // reset state
        vecs.push_back(mk(1, 1, 1, 32'h11,   1, 2, 32'h22,   0,   0, 0, 0,        1, 1, 0)); // tie capture
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        0,   1, 1, 32'h11,   1, 0, 1)); // FPU wins first tie
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        0,   1, 2, 32'h22,   1, 1, 1));
        vecs.push_back(mk(1, 1, 3, ONE_F,    0, 0, 0,        0,   0, 0, 0,        1, 1, 0)); // single source
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        0,   1, 3, ONE_F,    1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        0,   0, 0, 0,        1, 1, 0));
        vecs.push_back(mk(1, 1, 4, 32'h44,   1, 6, 32'h66,   0,   0, 0, 0,        1, 1, 0)); // tie after FPU write
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        0,   1, 6, 32'h66,   0, 1, 1)); // MEM first
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        0,   1, 4, 32'h44,   1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        0,   0, 0, 0,        1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0,        1, 5, DAT_A,    0,   0, 0, 0,        1, 1, 0)); // age: MEM at t
        vecs.push_back(mk(1, 1, 5, DAT_B,    0, 0, 0,        1,   0, 0, 0,        1, 0, 1)); // FPU at t+1, blocked
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        1,   0, 0, 0,        0, 0, 1)); // blocked
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        0,   1, 5, DAT_A,    0, 1, 1)); // older MEM first
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        0,   1, 5, DAT_B,    1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        0,   0, 0, 0,        1, 1, 0));
        vecs.push_back(mk(1, 1, 7, 32'h70,   1, 8, 32'h80,   0,   0, 0, 0,        1, 1, 0)); // backpressure fill
        vecs.push_back(mk(1, 1, 9, 32'h90,   0, 0, 0,        1,   0, 0, 0,        0, 0, 1)); // held, blocked
        vecs.push_back(mk(1, 1, 9, 32'h90,   0, 0, 0,        0,   1, 8, 32'h80,   0, 1, 1)); // MEM wins (last=FPU)
        vecs.push_back(mk(1, 1, 9, 32'h90,   0, 0, 0,        0,   1, 7, 32'h70,   1, 1, 1)); // granted: refill
        vecs.push_back(mk(1, 1, 10, 32'hA0,  0, 0, 0,        0,   1, 9, 32'h90,   1, 1, 1)); // no bubble
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        0,   1, 10, 32'hA0,  1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        0,   0, 0, 0,        1, 1, 0));
        vecs.push_back(mk(1, 1, 11, 32'hB0,  1, 12, 32'hC0,  0,   0, 0, 0,        1, 1, 0)); // fill both
        vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0,        0,   0, 0, 0,        0, 0, 1)); // reset beat: no write
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        0,   0, 0, 0,        1, 1, 0)); // cleared
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        0,   0, 0, 0,        1, 1, 0));
        vecs.push_back(mk(1, 1, 13, 32'hD0,  1, 14, 32'hE0,  0,   0, 0, 0,        1, 1, 0)); // tie after reset
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        0,   1, 13, 32'hD0,  1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        0,   1, 14, 32'hE0,  1, 1, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].fv, vecs[i].fa, vecs[i].fd,
                  vecs[i].mv, vecs[i].ma, vecs[i].md, vecs[i].blk);
            @(negedge clk_i);
            check_outs($sformatf("vec%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd,
                       vecs[i].fr, vecs[i].mr, vecs[i].busy);
            if (i == 16) check("reg5_final", regfile[5], DAT_B);
            @(posedge clk_i); #1;
        end

        // Streaming: eight back-to-back FPU beats, one write per cycle.
        for (int i = 0; i < 10; i++) begin
            drive(1, i < 8, 5'(16 + i), 32'h5000 + i, 0, 0, 0, 0);
            @(negedge clk_i);
            check($sformatf("stream%0d.fpu_rdy", i), {31'd0, fpu_ready_o}, 32'd1);
            if (i >= 1 && i <= 8) begin
                check($sformatf("stream%0d.we", i), {31'd0, fpr_we_o}, 32'd1);
                check($sformatf("stream%0d.waddr", i), {27'd0, fpr_waddr_o}, 32'(15 + i));
                check($sformatf("stream%0d.wdata", i), fpr_wdata_o, 32'h5000 + i - 1);
            end else begin
                check($sformatf("stream%0d.we", i), {31'd0, fpr_we_o}, 32'd0);
            end
            @(posedge clk_i); #1;
        end

        // Randomized traffic against the age/round-robin reference model.
        apply_reset();
        model_reset();
        cyc = 0;
        for (int n = 0; n < 3000; n++) begin
            bit r, fv, mv, blk, wr, fr, mr, busy, g_fpu, g_mem;
            logic [4:0] fa, ma, ea;
            logic [31:0] fd, md, ed;
            r   = ($urandom_range(0, 99) != 0);
            fv  = ($urandom_range(0, 99) < 60);
            mv  = ($urandom_range(0, 99) < 60);
            blk = ($urandom_range(0, 99) < 25);
            fa = 5'($urandom); ma = 5'($urandom); fd = $urandom; md = $urandom;
            drive(r, fv, fa, fd, mv, ma, md, blk);

            g_fpu = 0; g_mem = 0;
            if (m_fpu.full && m_mem.full) begin
                if (m_fpu.born != m_mem.born) g_fpu = (m_fpu.born < m_mem.born);
                else                          g_fpu = m_last_mem;
                g_mem = !g_fpu;
            end else begin
                g_fpu = m_fpu.full;
                g_mem = m_mem.full;
            end
            wr   = (g_fpu || g_mem) && !blk && r;
            ea   = !wr ? 5'd0  : (g_fpu ? m_fpu.addr : m_mem.addr);
            ed   = !wr ? 32'd0 : (g_fpu ? m_fpu.data : m_mem.data);
            fr   = !m_fpu.full || (wr && g_fpu);
            mr   = !m_mem.full || (wr && g_mem);
            busy = m_fpu.full || m_mem.full;

            @(negedge clk_i);
            check_outs($sformatf("rnd%0d", n), wr, ea, ed, fr, mr, busy);

            if (!r) begin
                model_reset();
            end else begin
                if (wr) begin
                    if (g_fpu) m_fpu.full = 0; else m_mem.full = 0;
                    m_last_mem = g_mem;
                end
                if (fv && fr) m_fpu = '{1, fa, fd, cyc};
                if (mv && mr) m_mem = '{1, ma, md, cyc};
            end
            cyc++;
            @(posedge clk_i); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
